// File: rtl/fifo_frame_writer.sv
// fifo_frame_writer: frames upstream payload as header/payload/checksum words into the async FIFO write port
module fifo_frame_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int LENGTH_WIDTH = 8,
    parameter int SEQ_WIDTH    = 8
) (
    input  logic                    clock_in,
    input  logic                    rst_in_n,
    input  logic                    frame_start_valid,
    output logic                    frame_start_ready,
    input  logic [LENGTH_WIDTH-1:0] frame_length,
    input  logic [DATA_WIDTH-1:0]   src_data,
    input  logic                    src_valid,
    output logic                    src_ready,
    output logic [DATA_WIDTH-1:0]   data_in,
    output logic                    data_in_valid,
    input  logic                    data_in_full,
    output logic                    frame_done,
    output logic                    busy,
    output logic [SEQ_WIDTH-1:0]    seq_num
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;
    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d, csum_q, csum_d, hdr;
    logic                    valid_q, valid_d, done_q, done_d, last_q, last_d, out_free, xfer;
    logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
    logic [LENGTH_WIDTH-1:0] rem_q, rem_d;

    assign out_free          = !valid_q || !data_in_full;
    assign xfer              = valid_q && !data_in_full;
    assign frame_start_ready = state_q == IDLE;
    assign src_ready         = state_q == PAYLOAD && out_free;
    assign data_in           = data_q;
    assign data_in_valid     = valid_q;
    assign frame_done        = done_q;
    assign seq_num           = seq_q;
    assign busy              = state_q != IDLE || valid_q;

    // frame sequencing; the output register only reloads once its current word has left
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q && data_in_full;
        csum_d  = csum_q;
        rem_d   = rem_q;
        seq_d   = seq_q;
        done_d  = last_q && xfer;
        last_d  = last_q && !xfer;
        hdr     = '0;
        hdr[LENGTH_WIDTH+SEQ_WIDTH-1:0] = {seq_q, rem_q};
        case (state_q)
            IDLE: if (frame_start_valid) begin
                rem_d   = frame_length;
                state_d = HEADER;
            end
            HEADER: if (out_free) begin
                data_d  = hdr;
                valid_d = 1'b1;
                csum_d  = hdr;
                state_d = rem_q == '0 ? CHECKSUM : PAYLOAD;
            end
            PAYLOAD: if (src_valid && out_free) begin
                data_d  = src_data;
                valid_d = 1'b1;
                csum_d  = csum_q + src_data;
                rem_d   = rem_q - 1'b1;
                state_d = rem_q == LENGTH_WIDTH'(1) ? CHECKSUM : PAYLOAD;
            end
            CHECKSUM: if (out_free) begin
                data_d  = csum_q;
                valid_d = 1'b1;
                last_d  = 1'b1;
                seq_d   = seq_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clock_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            csum_q  <= '0;
            rem_q   <= '0;
            seq_q   <= '0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            csum_q  <= csum_d;
            rem_q   <= rem_d;
            seq_q   <= seq_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_fifo_frame_writer.sv
// tb_fifo_frame_writer: directed checks of framing, back-pressure, sequence wrap and reset
module tb_fifo_frame_writer;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int SW = 8;

    logic          clock_in = 1'b0;
    logic          rst_in_n = 1'b0;
    logic          frame_start_valid = 1'b0;
    logic          frame_start_ready;
    logic [LW-1:0] frame_length = '0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_full = 1'b0;
    logic          frame_done;
    logic          busy;
    logic [SW-1:0] seq_num;

    fifo_frame_writer #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .SEQ_WIDTH(SW)) dut (
        .clock_in(clock_in),
        .rst_in_n(rst_in_n),
        .frame_start_valid(frame_start_valid),
        .frame_start_ready(frame_start_ready),
        .frame_length(frame_length),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_in_full(data_in_full),
        .frame_done(frame_done),
        .busy(busy),
        .seq_num(seq_num)
    );

    always #5 clock_in = ~clock_in;

    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    int            gap = 0;
    int            max_gap = 0;
    logic          meas = 1'b0;
    logic [DW-1:0] got[$];
    logic [DW-1:0] pay[0:7];
    logic [DW-1:0] exp_w[0:7];

    // FIFO-side observer: words that will transfer at the next posedge, done pulses, idle gaps
    always @(negedge clock_in) begin
        if (data_in_valid && !data_in_full) got.push_back(data_in);
        if (frame_done) done_cnt++;
        if (!meas) max_gap = 0;
        if (!meas || !busy) gap = 0;
        else if (data_in_valid) begin
            if (gap > max_gap) max_gap = gap;
            gap = 0;
        end else gap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask

    task automatic chk_words(input int base, input int n);
        chk("word_count", got.size() - base, n);
        for (int j = 0; j < n && base + j < got.size(); j++)
            chk($sformatf("word%0d", j), got[base+j], exp_w[j]);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_data_in", data_in, 0);
        chk("rst_valid", data_in_valid, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_seq", seq_num, 0);
        chk("rst_start_ready", frame_start_ready, 1);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_busy", busy, 0);
    endtask

    // one frame from pay[]; optional 5-cycle FIFO stall after word stall_i; may stop early
    task automatic run_frame(input int len, input int stall_i, input int stop_after);
        int k;
        int d0;
        d0 = done_cnt;
        frame_length = LW'(len);
        frame_start_valid = 1'b1;
        k = 0;
        while (!frame_start_ready && k < 50) begin tick; k++; end
        if (k == 50) chk("accept_timeout", 0, 1);
        tick;
        frame_start_valid = 1'b0;
        frame_length = frame_length ^ 8'hA5;
        for (int i = 0; i < stop_after; i++) begin
            src_data = pay[i];
            src_valid = 1'b1;
            k = 0;
            while (!src_ready && k < 50) begin tick; k++; end
            if (k == 50) chk("src_timeout", 0, 1);
            tick;
            if (i == stall_i) begin
                src_data = pay[i+1];
                data_in_full = 1'b1;
                #1;
                for (int c = 0; c < 5; c++) begin
                    chk("hold_data", data_in, pay[i]);
                    chk("hold_valid", data_in_valid, 1);
                    chk("hold_src_ready", src_ready, 0);
                    tick;
                end
                data_in_full = 1'b0;
                #1;
            end
        end
        src_valid = 1'b0;
        if (stop_after == len) begin
            k = 0;
            while (done_cnt == d0 && k < 100) begin tick; k++; end
            if (k == 100) chk("done_timeout", 0, 1);
        end
    endtask

    initial begin
        int base;
        int d0;
        int acc;
        int errs;
        logic cr;
        logic ca;
        logic [DW-1:0] h;
        logic [DW-1:0] p;

        // reset held with busy-looking inputs
        frame_start_valid = 1'b1;
        src_valid = 1'b1;
        frame_length = 8'h07;
        src_data = 32'hDEADBEEF;
        tick;
        data_in_full = 1'b1;
        tick;
        data_in_full = 1'b0;
        tick;
        chk_reset_outputs();
        frame_start_valid = 1'b0;
        src_valid = 1'b0;
        rst_in_n = 1'b1;
        tick;

        // length 3, no back-pressure
        base = got.size();
        pay = '{32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0};
        run_frame(3, -1, 3);
        repeat (3) tick;
        exp_w = '{32'h3, 32'h11, 32'h22, 32'h33, 32'h69, 0, 0, 0};
        chk_words(base, 5);
        chk("f1_done_pulses", done_cnt, 1);
        chk("f1_seq", seq_num, 1);
        chk("f1_idle", busy, 0);

        // length 0: header then checksum only
        base = got.size();
        run_frame(0, -1, 0);
        repeat (2) tick;
        exp_w = '{32'h100, 32'h100, 0, 0, 0, 0, 0, 0};
        chk_words(base, 2);
        chk("f2_seq", seq_num, 2);
        chk("f2_done_pulses", done_cnt, 2);

        // length 4 with FIFO full for 5 cycles while payload word 2 sits in the output register
        base = got.size();
        pay = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 0, 0, 0, 0};
        run_frame(4, 1, 4);
        repeat (2) tick;
        exp_w = '{32'h204, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'hA204, 0, 0};
        chk_words(base, 6);
        chk("f3_seq", seq_num, 3);

        // fresh start so the sequence counter wraps exactly at 256 frames
        rst_in_n = 1'b0;
        tick;
        chk("mid_reset_seq", seq_num, 0);
        rst_in_n = 1'b1;
        tick;

        // 256 back-to-back length-1 frames with request and source held valid
        base = got.size();
        d0 = done_cnt;
        acc = 0;
        meas = 1'b1;
        frame_length = 8'd1;
        frame_start_valid = 1'b1;
        src_valid = 1'b1;
        src_data = 32'hA000_0000;
        for (int c = 0; c < 3000 && done_cnt < d0 + 256; c++) begin
            cr = src_ready;
            ca = frame_start_valid && frame_start_ready;
            tick;
            if (cr) src_data = src_data + 1;
            if (ca) begin
                acc++;
                if (acc == 256) frame_start_valid = 1'b0;
            end
        end
        src_valid = 1'b0;
        tick;
        chk("stream_gap", max_gap <= 1, 1);
        meas = 1'b0;
        chk("stream_frames", done_cnt - d0, 256);
        chk("stream_words", got.size() - base, 768);
        errs = 0;
        for (int k = 0; k < 256 && base + 3 * k + 2 < got.size(); k++) begin
            h = (DW'(k) << 8) | 32'h1;
            p = 32'hA000_0000 + DW'(k);
            if (got[base+3*k] !== h || got[base+3*k+1] !== p || got[base+3*k+2] !== h + p) errs++;
        end
        chk("stream_content", errs, 0);
        chk("stream_seq_wrap", seq_num, 0);

        // reset after 2 payload words of a length-5 frame
        pay = '{32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 0, 0, 0};
        run_frame(5, -1, 2);
        chk("cut_busy_before", busy, 1);
        d0 = done_cnt;
        rst_in_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) tick;
        rst_in_n = 1'b1;
        repeat (4) tick;
        chk("cut_no_done", done_cnt, d0);

        // carry discarded in checksum; first frame after reset carries seq 0
        base = got.size();
        pay = '{32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 0, 0};
        run_frame(2, -1, 2);
        repeat (2) tick;
        exp_w = '{32'h2, 32'hFFFF_FFFF, 32'h2, 32'h3, 0, 0, 0, 0};
        chk_words(base, 4);
        chk("f5_seq", seq_num, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
